// File: rtl/padd_pkg.sv
// Shared types and arithmetic helper for the padd_pipe pre-adder.
// sat_add works at a fixed wide precision; callers keep the low WIDTH bits.
package padd_pkg;

    localparam logic [1:0] MODE_ADD    = 2'b00;
    localparam logic [1:0] MODE_SUB    = 2'b01;
    localparam logic [1:0] MODE_PASS_A = 2'b10;
    localparam logic [1:0] MODE_PASS_B = 2'b11;

    localparam int CALC_W = 64;

    typedef enum logic [1:0] {
        PADD_ADD    = MODE_ADD,
        PADD_SUB    = MODE_SUB,
        PADD_PASS_A = MODE_PASS_A,
        PADD_PASS_B = MODE_PASS_B
    } padd_mode_e;

    typedef struct packed {
        logic                     ovf;
        logic signed [CALC_W-1:0] res;
    } sat_res_t;

    // Operands arrive sign-extended from w bits, so the exact result always
    // fits in w+1 bits; a range test is the same as the top-two-sign-bit test.
    function automatic sat_res_t sat_add(
        input logic signed [CALC_W-1:0] a,
        input logic signed [CALC_W-1:0] b,
        input padd_mode_e               mode,
        input int unsigned              w,
        input logic                     sat_en
    );
        logic signed [CALC_W-1:0] sum;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        sat_res_t                 r;
        hi = (CALC_W'(64'sd1) <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        case (mode)
            PADD_ADD:    sum = a + b;
            PADD_SUB:    sum = a - b;
            PADD_PASS_A: sum = a;
            default:     sum = b;
        endcase
        r.ovf = ((mode == PADD_ADD) || (mode == PADD_SUB)) && ((sum > hi) || (sum < lo));
        r.res = sum;
        if (r.ovf && sat_en) begin
            r.res = (sum < 0) ? lo : hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/padd_lane.sv
// One pre-adder lane: shift-out registers, optional operand stage, arithmetic
// and one or two output registers. Valid and mode pipelines live in the top.
module padd_lane
    import padd_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int STAGES = 2,
    parameter int SAT_EN = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce,
    input  logic                    clr,
    input  logic                    a_sel,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] si,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] sbi,
    input  padd_mode_e              mode,
    output logic signed [WIDTH-1:0] so,
    output logic signed [WIDTH-1:0] sbo,
    output logic signed [WIDTH-1:0] dout,
    output logic                    ovf
);

    logic signed [WIDTH-1:0] a_mux;
    logic signed [WIDTH-1:0] so_p0;
    logic signed [WIDTH-1:0] sbo_p0;
    logic signed [WIDTH-1:0] op_a;
    logic signed [WIDTH-1:0] op_b;
    sat_res_t                calc;
    logic signed [WIDTH-1:0] res_c;
    logic signed [WIDTH-1:0] res_p1;
    logic                    ovf_p1;
    logic                    unused_calc_hi;

    assign a_mux = a_sel ? si : a;

    // stage p0: shift-out registers (always one cycle, whatever STAGES is)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            so_p0  <= '0;
            sbo_p0 <= '0;
        end else if (ce) begin
            if (clr) begin
                so_p0  <= '0;
                sbo_p0 <= '0;
            end else begin
                so_p0  <= a_mux;
                sbo_p0 <= a_sel ? sbi : b;
            end
        end
    end

    assign so  = so_p0;
    assign sbo = sbo_p0;

    // The selected-A shift-out register doubles as the A operand stage.
    generate
        if (STAGES == 1) begin : g_comb_in
            assign op_a = a_mux;
            assign op_b = b;
        end else begin : g_reg_in
            logic signed [WIDTH-1:0] b_p0;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    b_p0 <= '0;
                end else if (ce) begin
                    b_p0 <= clr ? '0 : b;
                end
            end
            assign op_a = so_p0;
            assign op_b = b_p0;
        end
    endgenerate

    always_comb begin
        calc = sat_add(CALC_W'(op_a), CALC_W'(op_b), mode, WIDTH, SAT_EN != 0);
    end

    assign res_c          = calc.res[WIDTH-1:0];
    assign unused_calc_hi = ^calc.res[CALC_W-1:WIDTH];

    // stage p1: result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_p1 <= '0;
            ovf_p1 <= 1'b0;
        end else if (ce) begin
            res_p1 <= clr ? '0 : res_c;
            ovf_p1 <= clr ? 1'b0 : calc.ovf;
        end
    end

    generate
        if (STAGES == 3) begin : g_out2
            logic signed [WIDTH-1:0] res_p2;
            logic                    ovf_p2;
            // stage p2: extra output register
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    res_p2 <= '0;
                    ovf_p2 <= 1'b0;
                end else if (ce) begin
                    res_p2 <= clr ? '0 : res_p1;
                    ovf_p2 <= clr ? 1'b0 : ovf_p1;
                end
            end
            assign dout = res_p2;
            assign ovf  = ovf_p2;
        end else begin : g_out1
            assign dout = res_p1;
            assign ovf  = ovf_p1;
        end
    endgenerate

endmodule

// File: rtl/padd_pipe.sv
// Multi-lane pipelined pre-adder with shift chains and optional saturation.
// Valid and mode pipelines are shared; per-lane data lives in padd_lane.
module padd_pipe
    import padd_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int SAT_EN = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [1:0]             mode,
    input  logic                   a_sel,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [LANES*WIDTH-1:0] si,
    input  logic [LANES*WIDTH-1:0] sbi,
    output logic [LANES*WIDTH-1:0] dout,
    output logic                   out_valid,
    output logic [LANES-1:0]       ovf,
    output logic [LANES*WIDTH-1:0] so,
    output logic [LANES*WIDTH-1:0] sbo
);

    logic [STAGES-1:0] vld_p;
    padd_mode_e        mode_x;

    // valid pipeline, one bit per stage; clr wins over in_valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
        end else if (ce) begin
            vld_p[0] <= in_valid & ~clr;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1] & ~clr;
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];

    generate
        if (STAGES == 1) begin : g_mode_comb
            assign mode_x = padd_mode_e'(mode);
        end else begin : g_mode_reg
            padd_mode_e mode_p0;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mode_p0 <= PADD_ADD;
                end else if (ce) begin
                    mode_p0 <= clr ? PADD_ADD : padd_mode_e'(mode);
                end
            end
            assign mode_x = mode_p0;
        end
    endgenerate

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            padd_lane #(
                .WIDTH  (WIDTH),
                .STAGES (STAGES),
                .SAT_EN (SAT_EN)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .ce      (ce),
                .clr     (clr),
                .a_sel   (a_sel),
                .a       (a[g*WIDTH +: WIDTH]),
                .si      (si[g*WIDTH +: WIDTH]),
                .b       (b[g*WIDTH +: WIDTH]),
                .sbi     (sbi[g*WIDTH +: WIDTH]),
                .mode    (mode_x),
                .so      (so[g*WIDTH +: WIDTH]),
                .sbo     (sbo[g*WIDTH +: WIDTH]),
                .dout    (dout[g*WIDTH +: WIDTH]),
                .ovf     (ovf[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_padd_pipe.sv
// Scoreboard bench for padd_pipe: one wrapping and one saturating instance
// share stimulus; an arithmetic reference model predicts every valid beat.
module tb_padd_pipe;

    localparam int W    = 18;
    localparam int L    = 2;
    localparam int ST   = 2;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic           clk = 1'b0;
    logic           reset_n;
    logic           ce, clr, in_valid, a_sel;
    logic [1:0]     mode;
    logic [L*W-1:0] a, b, si, sbi;
    logic [L*W-1:0] dout0, dout1, so0, so1, sbo0, sbo1;
    logic [L-1:0]   ovf0, ovf1;
    logic           ov0, ov1;

    typedef struct {
        logic [L*W-1:0] d0;
        logic [L*W-1:0] d1;
        logic [L-1:0]   o;
        int             out_edge;
    } exp_t;

    exp_t           q[$];
    int             checks = 0;
    int             errors = 0;
    int             ecount = 0;
    logic [L*W-1:0] so_exp, sbo_exp;
    bit             so_known = 0;

    always #5 clk = ~clk;

    padd_pipe #(.WIDTH(W), .LANES(L), .STAGES(ST), .SAT_EN(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .ce(ce), .clr(clr), .in_valid(in_valid),
        .mode(mode), .a_sel(a_sel), .a(a), .b(b), .si(si), .sbi(sbi),
        .dout(dout0), .out_valid(ov0), .ovf(ovf0), .so(so0), .sbo(sbo0)
    );

    padd_pipe #(.WIDTH(W), .LANES(L), .STAGES(ST), .SAT_EN(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .ce(ce), .clr(clr), .in_valid(in_valid),
        .mode(mode), .a_sel(a_sel), .a(a), .b(b), .si(si), .sbi(sbi),
        .dout(dout1), .out_valid(ov1), .ovf(ovf1), .so(so1), .sbo(sbo1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [L*W-1:0] pk(input int l0, input int l1);
        return {l1[W-1:0], l0[W-1:0]};
    endfunction

    // Reference: exact integer result, then wrap (mod 2^W) or clamp.
    function automatic exp_t predict(input logic [1:0] m, input logic [L*W-1:0] av,
                                     input logic [L*W-1:0] bv, input int oe);
        exp_t e;
        e.out_edge = oe;
        for (int i = 0; i < L; i++) begin
            logic signed [W-1:0] xa, xb;
            int ai, bi, full, sat;
            bit o;
            xa = av[i*W +: W];
            xb = bv[i*W +: W];
            ai = int'(xa);
            bi = int'(xb);
            case (m)
                2'b00:   full = ai + bi;
                2'b01:   full = ai - bi;
                2'b10:   full = ai;
                default: full = bi;
            endcase
            o   = (m < 2) && (full > MAXV || full < MINV);
            sat = (full > MAXV) ? MAXV : ((full < MINV) ? MINV : full);
            e.d0[i*W +: W] = W'(full);
            e.d1[i*W +: W] = W'(sat);
            e.o[i] = o;
        end
        return e;
    endfunction

    task automatic drive(input bit v, input logic [1:0] m, input bit sel, input bit c,
                         input bit cl, input logic [L*W-1:0] av, input logic [L*W-1:0] bv,
                         input logic [L*W-1:0] siv, input logic [L*W-1:0] sbiv);
        @(negedge clk);
        in_valid = v; mode = m; a_sel = sel; ce = c; clr = cl;
        a = av; b = bv; si = siv; sbi = sbiv;
        if (c) begin
            if (cl) begin
                q.delete();
                so_known = 0;
            end else begin
                if (v) q.push_back(predict(m, sel ? siv : av, bv, ecount + ST));
                so_exp   = sel ? siv : av;
                sbo_exp  = sel ? sbiv : bv;
                so_known = 1;
            end
        end
        @(posedge clk);
        #1;
        if (so_known) begin
            chk("so_wrap", so0, so_exp);
            chk("sbo_wrap", sbo0, sbo_exp);
            chk("so_sat", so1, so_exp);
            chk("sbo_sat", sbo1, sbo_exp);
        end
    endtask

    task automatic beat(input logic [1:0] m, input bit sel, input logic [L*W-1:0] av,
                        input logic [L*W-1:0] bv, input logic [L*W-1:0] siv,
                        input logic [L*W-1:0] sbiv);
        drive(1, m, sel, 1, 0, av, bv, siv, sbiv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 2'b00, 0, 1, 0, '0, '0, '0, '0);
    endtask

    task automatic areset();
        @(negedge clk);
        ce = 1; in_valid = 0; clr = 0;
        #2 reset_n = 0;
        #1;
        chk("async_dout_wrap", dout0, '0);
        chk("async_dout_sat", dout1, '0);
        chk("async_so", so0, '0);
        chk("async_valid", ov0, 0);
        q.delete();
        so_known = 0;
        #1 reset_n = 1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return W'(MAXV);
            1:       return W'(MINV);
            2:       return W'(int'($urandom_range(0, 8)) - 4);
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: pops one expectation per valid output on an enabled edge.
    bit             m_ce, m_rst;
    logic [L*W-1:0] prev_d0, prev_d1;
    logic           prev_v;
    exp_t           e;
    always @(posedge clk) begin
        m_ce  = ce;
        m_rst = reset_n;
        #1;
        if (m_rst) begin
            if (m_ce) begin
                ecount++;
                chk("valid_match", ov1, ov0);
                if (ov0) begin
                    if (q.size() == 0) begin
                        chk("spurious_valid", ov0, 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency_edge", 64'(ecount), 64'(e.out_edge));
                        chk("dout_wrap", dout0, e.d0);
                        chk("dout_sat", dout1, e.d1);
                        chk("ovf_wrap", ovf0, e.o);
                        chk("ovf_sat", ovf1, e.o);
                    end
                end else if (q.size() > 0 && q[0].out_edge <= ecount) begin
                    chk("missing_valid", ov0, 1);
                    void'(q.pop_front());
                end
            end else begin
                chk("hold_dout_wrap", dout0, prev_d0);
                chk("hold_dout_sat", dout1, prev_d1);
                chk("hold_valid", ov0, prev_v);
            end
        end
        prev_d0 = dout0;
        prev_d1 = dout1;
        prev_v  = ov0;
    end

    initial begin
        reset_n = 0; ce = 0; clr = 0; in_valid = 0; mode = 2'b00; a_sel = 0;
        a = '0; b = '0; si = '0; sbi = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout0, '0);
        chk("rst_so", so0, '0);
        chk("rst_sbo", sbo0, '0);
        chk("rst_ovf", ovf1, '0);
        chk("rst_valid", ov1, 0);
        @(negedge clk);
        reset_n = 1;

        // directed vectors
        beat(2'b00, 0, pk(20, 0), pk(3, 0), '0, '0);
        beat(2'b01, 1, pk(99, 99), pk(12, 12), pk(5, 5), pk(7, 8));
        beat(2'b00, 0, pk(MAXV, 0), pk(1, 0), '0, '0);
        beat(2'b01, 0, pk(MINV, MINV), pk(1, -1), '0, '0);
        beat(2'b00, 0, pk(10, -3), pk(5, -4), '0, '0);
        beat(2'b10, 0, pk(MAXV, 7), pk(1, 9), '0, '0);
        beat(2'b11, 1, pk(1, 2), pk(MINV, 3), pk(4, 5), '0);
        drive(0, 2'b00, 0, 1, 0, pk(1, 1), pk(1, 1), '0, '0);
        idle(3);

        // ce stall mid-stream; clr and in_valid during the stall are ignored
        beat(2'b00, 0, pk(1, 1), pk(1, 1), '0, '0);
        beat(2'b00, 0, pk(2, 2), pk(2, 2), '0, '0);
        for (int i = 0; i < 4; i++) drive(1, 2'b01, 1, 0, 1, pk(50, 50), pk(9, 9), pk(7, 7), '0);
        beat(2'b00, 0, pk(3, 3), pk(3, 3), '0, '0);
        idle(3);

        // clr with two beats in flight
        beat(2'b00, 0, pk(11, 11), pk(1, 1), '0, '0);
        beat(2'b00, 0, pk(12, 12), pk(1, 1), '0, '0);
        drive(1, 2'b00, 0, 1, 1, pk(13, 13), pk(1, 1), '0, '0);
        idle(3);

        // async reset with beats in flight
        beat(2'b00, 0, pk(21, 21), pk(1, 1), '0, '0);
        beat(2'b00, 0, pk(22, 22), pk(1, 1), '0, '0);
        areset();
        idle(3);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom),
                  $urandom_range(0, 6) != 0, $urandom_range(0, 30) == 0,
                  {rnd_op(), rnd_op()}, {rnd_op(), rnd_op()},
                  {rnd_op(), rnd_op()}, {rnd_op(), rnd_op()});
        end
        idle(ST + 3);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
